wh_row_mac: RTL and testbench

//  Downstream consumer of the per-column weight BRAMs built by the weight loader.
//  - Streams one sparse H row at a time: node_info header, then row_len (value, col_idx) entries.
//  - Reads all NUM_FEATURE_OUT weight columns in parallel at col_idx.
//  - Multiply-accumulates into one WH row and emits it with num_nodes/flag to the DMVM/WH buffer.

---
 rtl/wh_row_mac.sv | 188 ++++++++++++++++++
 tb/tb_wh_row_mac.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wh_row_mac.sv
// Sparse H row x dense W multiply-accumulate: one WH row of NUM_FEATURE_OUT elements per H row.
// Optional macro WH_SATURATE_EN clamps each element instead of truncating to WH_DATA_WIDTH.
module wh_row_mac #(
  parameter int DATA_WIDTH      = 8,
  parameter int WH_DATA_WIDTH   = 12,
  parameter int NUM_FEATURE_IN  = 1433,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int MAX_NODES       = 168,
  localparam int COL_IDX_W = $clog2(NUM_FEATURE_IN),
  localparam int MW_ADDR_W = $clog2(NUM_FEATURE_IN * 10),
  localparam int NN_W      = $clog2(MAX_NODES),
  localparam int ACC_W     = 2 * DATA_WIDTH + COL_IDX_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        w_rdy_i,
  input  logic                                        ni_vld_i,
  output logic                                        ni_rdy_o,
  input  logic [COL_IDX_W+NN_W:0]                     ni_data_i,
  input  logic                                        h_vld_i,
  output logic                                        h_rdy_o,
  input  logic [DATA_WIDTH+COL_IDX_W-1:0]             h_data_i,
  output logic [NUM_FEATURE_OUT*MW_ADDR_W-1:0]        mult_wgt_addrb_flat,
  input  logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0]       mult_wgt_dout_flat,
  output logic                                        wh_vld_o,
  input  logic                                        wh_rdy_i,
  output logic [NUM_FEATURE_OUT*WH_DATA_WIDTH+NN_W:0] wh_data_o,
  output logic                                        busy_o
);

  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int OUT_W   = NUM_FEATURE_OUT * WH_DATA_WIDTH + NN_W + 1;
`ifdef WH_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (WH_DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (WH_DATA_WIDTH - 1)));
`endif

  typedef enum logic [2:0] {IDLE, HDR, MAC, DRAIN, OUT} state_e;

  state_e                        state_q, state_d;
  logic [COL_IDX_W-1:0]          rem_q, rem_d;
  logic [NN_W-1:0]               num_nodes_q, num_nodes_d;
  logic                          flag_q, flag_d;
  logic                          s1_vld_q, s1_vld_d;
  logic signed [DATA_WIDTH-1:0]  s1_val_q, s1_val_d;
  logic                          drain_wait_q, drain_wait_d;
  logic                          wh_vld_q, wh_vld_d;
  logic [OUT_W-1:0]              wh_data_q, wh_data_d;
  logic signed [ACC_W-1:0]       acc_q [NUM_FEATURE_OUT];
  logic signed [ACC_W-1:0]       acc_d [NUM_FEATURE_OUT];

  logic signed [DATA_WIDTH-1:0]  w_lane [NUM_FEATURE_OUT];
  logic signed [PROD_W-1:0]      prod   [NUM_FEATURE_OUT];
  logic [WH_DATA_WIDTH-1:0]      wh_red [NUM_FEATURE_OUT];

  logic [COL_IDX_W-1:0]          hdr_row_len;
  logic [NN_W-1:0]               hdr_num_nodes;
  logic                          hdr_flag;
  logic signed [DATA_WIDTH-1:0]  h_val;
  logic [COL_IDX_W-1:0]          h_col;
  logic                          h_fire;

  assign {hdr_row_len, hdr_num_nodes, hdr_flag} = ni_data_i;
  assign {h_val, h_col} = h_data_i;

  // Ready outputs depend on state only, never on the matching valid input.
  assign ni_rdy_o  = (state_q == HDR);
  assign h_rdy_o   = (state_q == MAC) && (rem_q != '0);
  assign h_fire    = h_vld_i && h_rdy_o;
  assign busy_o    = (state_q != IDLE);
  assign wh_vld_o  = wh_vld_q;
  assign wh_data_o = wh_data_q;

  always_comb begin
    mult_wgt_addrb_flat = '0;
    for (int k = 0; k < NUM_FEATURE_OUT; k++) begin
      w_lane[k] = mult_wgt_dout_flat[k*DATA_WIDTH +: DATA_WIDTH];
      prod[k]   = s1_val_q * w_lane[k];
      mult_wgt_addrb_flat[k*MW_ADDR_W +: MW_ADDR_W] = h_rdy_o ? MW_ADDR_W'(h_col) : '0;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FEATURE_OUT; k++) begin
`ifdef WH_SATURATE_EN
      if (acc_q[k] > ACC_MAX) begin
        wh_red[k] = ACC_MAX[WH_DATA_WIDTH-1:0];
      end else if (acc_q[k] < ACC_MIN) begin
        wh_red[k] = ACC_MIN[WH_DATA_WIDTH-1:0];
      end else begin
        wh_red[k] = acc_q[k][WH_DATA_WIDTH-1:0];
      end
`else
      wh_red[k] = acc_q[k][WH_DATA_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    num_nodes_d  = num_nodes_q;
    flag_d       = flag_q;
    s1_vld_d     = 1'b0;
    s1_val_d     = s1_val_q;
    drain_wait_d = drain_wait_q;
    wh_vld_d     = wh_vld_q;
    wh_data_d    = wh_data_q;
    for (int k = 0; k < NUM_FEATURE_OUT; k++) begin
      acc_d[k] = acc_q[k];
      if (s1_vld_q) begin
        acc_d[k] = acc_q[k] + $signed({{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]});
      end
    end

    case (state_q)
      IDLE: begin
        if (w_rdy_i) state_d = HDR;
      end
      HDR: begin
        if (ni_vld_i) begin
          num_nodes_d  = hdr_num_nodes;
          flag_d       = hdr_flag;
          rem_d        = hdr_row_len;
          drain_wait_d = 1'b0;
          for (int k = 0; k < NUM_FEATURE_OUT; k++) acc_d[k] = '0;
          state_d = (hdr_row_len == '0) ? DRAIN : MAC;
        end
      end
      MAC: begin
        if (h_fire) begin
          s1_vld_d = 1'b1;
          s1_val_d = h_val;
          rem_d    = rem_q - COL_IDX_W'(1);
          if (rem_q == COL_IDX_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // First cycle lets the last stage-1 product land in the accumulators.
        if (!drain_wait_q) begin
          drain_wait_d = 1'b1;
        end else begin
          for (int k = 0; k < NUM_FEATURE_OUT; k++) begin
            wh_data_d[NN_W+1+k*WH_DATA_WIDTH +: WH_DATA_WIDTH] = wh_red[k];
          end
          wh_data_d[NN_W:1] = num_nodes_q;
          wh_data_d[0]      = flag_q;
          wh_vld_d          = 1'b1;
          state_d           = OUT;
        end
      end
      OUT: begin
        if (wh_rdy_i) begin
          wh_vld_d = 1'b0;
          state_d  = w_rdy_i ? HDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      num_nodes_q  <= '0;
      flag_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_val_q     <= '0;
      drain_wait_q <= 1'b0;
      wh_vld_q     <= 1'b0;
      wh_data_q    <= '0;
      for (int k = 0; k < NUM_FEATURE_OUT; k++) acc_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      num_nodes_q  <= num_nodes_d;
      flag_q       <= flag_d;
      s1_vld_q     <= s1_vld_d;
      s1_val_q     <= s1_val_d;
      drain_wait_q <= drain_wait_d;
      wh_vld_q     <= wh_vld_d;
      wh_data_q    <= wh_data_d;
      for (int k = 0; k < NUM_FEATURE_OUT; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_wh_row_mac.sv
// Self-checking bench for wh_row_mac: random sparse rows against an arithmetic row model,
// with a 1-cycle-latency weight BRAM model driven by the DUT read addresses.
module tb_wh_row_mac;

  localparam int DW   = 8;
  localparam int WHW  = 12;
  localparam int NFI  = 1433;
  localparam int NFO  = 16;
  localparam int MAXN = 168;
  localparam int CW   = $clog2(NFI);
  localparam int AW   = $clog2(NFI * 10);
  localparam int NNW  = $clog2(MAXN);
  localparam int OW   = NFO * WHW + NNW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_rdy_i = 1'b0;
  logic ni_vld_i = 1'b0;
  logic h_vld_i = 1'b0;
  logic wh_rdy_i = 1'b0;
  logic [CW+NNW:0]   ni_data_i = '0;
  logic [DW+CW-1:0]  h_data_i = '0;
  logic [NFO*DW-1:0] dout = '0;
  logic              ni_rdy_o, h_rdy_o, wh_vld_o, busy_o;
  logic [NFO*AW-1:0] addrb;
  logic [OW-1:0]     wh_data_o;

  int total = 0;
  int bad = 0;
  int h_rdy_seen = 0;
  int ni_rdy_seen = 0;
  int wh_hs_cnt = 0;

  logic signed [DW-1:0] wmem [NFO][NFI];
  int ev[$];
  int ec[$];

  wh_row_mac dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .w_rdy_i             (w_rdy_i),
    .ni_vld_i            (ni_vld_i),
    .ni_rdy_o            (ni_rdy_o),
    .ni_data_i           (ni_data_i),
    .h_vld_i             (h_vld_i),
    .h_rdy_o             (h_rdy_o),
    .h_data_i            (h_data_i),
    .mult_wgt_addrb_flat (addrb),
    .mult_wgt_dout_flat  (dout),
    .wh_vld_o            (wh_vld_o),
    .wh_rdy_i            (wh_rdy_i),
    .wh_data_o           (wh_data_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  // Per-column weight BRAMs, one cycle of read latency, each lane uses its own address.
  always @(posedge clk) begin
    for (int k = 0; k < NFO; k++) begin
      automatic int a = int'(addrb[k*AW +: AW]);
      dout[k*DW +: DW] <= (a < NFI) ? wmem[k][a] : '0;
    end
  end

  always @(negedge clk) begin
    if (h_rdy_o) h_rdy_seen++;
    if (ni_rdy_o) ni_rdy_seen++;
    if (wh_vld_o && wh_rdy_i) wh_hs_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_w(input int mode);
    for (int k = 0; k < NFO; k++) begin
      for (int r = 0; r < NFI; r++) begin
        case (mode)
          0:       wmem[k][r] = DW'(k + 1);
          1:       wmem[k][r] = DW'(127);
          default: wmem[k][r] = DW'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic new_row_rand(input int n);
    ev.delete();
    ec.delete();
    repeat (n) begin
      ev.push_back(int'($urandom_range(0, 255)) - 128);
      ec.push_back(int'($urandom_range(0, NFI - 1)));
    end
  endtask

  function automatic logic [WHW-1:0] reduce(input int s);
`ifdef WH_SATURATE_EN
    if (s > 2047) return 12'h7ff;
    if (s < -2048) return 12'h800;
    return WHW'(s);
`else
    return WHW'(s);
`endif
  endfunction

  // WH row = sum over entries of value * W[col][k], then reduced to WHW bits.
  function automatic logic [OW-1:0] model_row(input int nn, input int fl);
    logic [OW-1:0] r;
    int s;
    r = '0;
    r[0] = 1'(fl);
    r[NNW:1] = NNW'(nn);
    for (int k = 0; k < NFO; k++) begin
      s = 0;
      for (int e = 0; e < ev.size(); e++) s += ev[e] * int'(wmem[k][ec[e]]);
      r[NNW+1+k*WHW +: WHW] = reduce(s);
    end
    return r;
  endfunction

  task automatic send_hdr(input int nn, input int fl, output int ok);
    ni_vld_i = 1'b1;
    ni_data_i = {CW'(ev.size()), NNW'(nn), 1'(fl)};
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      if (ni_rdy_o) ok = 1;
      step();
    end
    ni_vld_i = 1'b0;
  endtask

  task automatic send_entries(input bit gaps, output int ok, output int edges);
    int got;
    edges = 0;
    ok = 1;
    for (int e = 0; e < ev.size(); e++) begin
      if (gaps && e > 0) begin
        h_vld_i = 1'b0;
        step();
        edges++;
      end
      h_vld_i = 1'b1;
      h_data_i = {DW'(ev[e]), CW'(ec[e])};
      got = 0;
      for (int i = 0; i < 40 && got == 0; i++) begin
        if (h_rdy_o) got = 1;
        step();
        edges++;
      end
      if (got == 0) ok = 0;
    end
    h_vld_i = 1'b0;
  endtask

  task automatic wait_wh(output int ok, inout int edges);
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      if (wh_vld_o) ok = 1;
      else begin
        step();
        edges++;
      end
    end
  endtask

  task automatic run_to_out(input int nn, input int fl, input bit gaps, output int ok, output int edges);
    int o1, o2, o3;
    send_hdr(nn, fl, o1);
    send_entries(gaps, o2, edges);
    wait_wh(o3, edges);
    ok = o1 & o2 & o3;
  endtask

  task automatic do_wh_hs();
    wh_rdy_i = 1'b1;
    step();
    wh_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ni_rdy_o, h_rdy_o, wh_vld_o, busy_o} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0000", {ni_rdy_o, h_rdy_o, wh_vld_o, busy_o});
    end
    rst_n = 1'b1;
    step();
    total++;
    if (wh_data_o !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data got=%h exp=0", wh_data_o);
    end
    total++;
    if (addrb !== '0) begin
      bad++;
      $display("[TB] FAIL reset_addr got=%h exp=0", addrb);
    end
  endtask

  task automatic test_idle_hold();
    int snap;
    w_rdy_i = 1'b0;
    ni_vld_i = 1'b1;
    snap = ni_rdy_seen;
    repeat (10) step();
    total++;
    if (ni_rdy_seen - snap !== 0) begin
      bad++;
      $display("[TB] FAIL idle_ni_rdy got=%0d exp=0", ni_rdy_seen - snap);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_busy got=%b exp=0", busy_o);
    end
    ni_vld_i = 1'b0;
    w_rdy_i = 1'b1;
  endtask

  task automatic test_basic();
    int ok, edges, snap;
    logic [OW-1:0] exp;
    fill_w(0);
    ev = '{2, -1, 3};
    ec = '{0, 7, 1432};
    exp = model_row(5, 1);
    run_to_out(5, 1, 1'b0, ok, edges);
    total++;
    if (ok !== 1) begin
      bad++;
      $display("[TB] FAIL basic_handshake got=%0d exp=1", ok);
    end
    total++;
    if (edges !== 5) begin
      bad++;
      $display("[TB] FAIL basic_latency got=%0d exp=5", edges);
    end
    total++;
    if (wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL basic_data got=%h exp=%h", wh_data_o, exp);
    end
    total++;
    if (wh_data_o[NNW+1 +: WHW] !== 12'd4 || wh_data_o[NNW+1+15*WHW +: WHW] !== 12'd64) begin
      bad++;
      $display("[TB] FAIL basic_lanes got=%0d,%0d exp=4,64", wh_data_o[NNW+1 +: WHW],
               wh_data_o[NNW+1+15*WHW +: WHW]);
    end
    snap = wh_hs_cnt;
    do_wh_hs();
    total++;
    if (wh_vld_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_vld_drop got=%b exp=0", wh_vld_o);
    end
    total++;
    if (ni_rdy_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_back_to_hdr got=%b exp=1", ni_rdy_o);
    end
    total++;
    if (wh_hs_cnt - snap !== 1) begin
      bad++;
      $display("[TB] FAIL basic_pulses got=%0d exp=1", wh_hs_cnt - snap);
    end
  endtask

  task automatic test_empty_row();
    int ok, edges, snap;
    logic [OW-1:0] exp;
    ev.delete();
    ec.delete();
    exp = '0;
    exp[NNW:1] = NNW'(2);
    snap = h_rdy_seen;
    run_to_out(2, 0, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || edges !== 2) begin
      bad++;
      $display("[TB] FAIL empty_latency got=%0d ok=%0d exp=2", edges, ok);
    end
    total++;
    if (wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL empty_data got=%h exp=%h", wh_data_o, exp);
    end
    total++;
    if (h_rdy_seen - snap !== 0) begin
      bad++;
      $display("[TB] FAIL empty_h_rdy got=%0d exp=0", h_rdy_seen - snap);
    end
    w_rdy_i = 1'b0;
    do_wh_hs();
    total++;
    if (busy_o !== 1'b0 || ni_rdy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL empty_to_idle got=%b%b exp=00", busy_o, ni_rdy_o);
    end
    w_rdy_i = 1'b1;
  endtask

  task automatic test_backpressure();
    int ok, edges, snap, unstable;
    logic [OW-1:0] exp;
    fill_w(2);
    new_row_rand(6);
    exp = model_row(17, 1);
    run_to_out(17, 1, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL bp_first got=%h exp=%h", wh_data_o, exp);
    end
    new_row_rand(4);
    ni_vld_i = 1'b1;
    ni_data_i = {CW'(4), NNW'(99), 1'b0};
    snap = ni_rdy_seen;
    unstable = 0;
    repeat (10) begin
      if (wh_data_o !== exp || wh_vld_o !== 1'b1) unstable++;
      step();
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("[TB] FAIL bp_stable got=%0d exp=0", unstable);
    end
    total++;
    if (ni_rdy_seen - snap !== 0) begin
      bad++;
      $display("[TB] FAIL bp_ni_rdy got=%0d exp=0", ni_rdy_seen - snap);
    end
    do_wh_hs();
    exp = model_row(99, 0);
    run_to_out(99, 0, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL bp_next got=%h exp=%h", wh_data_o, exp);
    end
    do_wh_hs();
  endtask

  task automatic test_gaps();
    int ok, edges;
    logic [OW-1:0] exp;
    new_row_rand(4);
    exp = model_row(33, 0);
    run_to_out(33, 0, 1'b1, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL gaps_data got=%h exp=%h", wh_data_o, exp);
    end
    do_wh_hs();
    run_to_out(33, 0, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL nogaps_data got=%h exp=%h", wh_data_o, exp);
    end
    total++;
    if (edges !== 6) begin
      bad++;
      $display("[TB] FAIL nogaps_latency got=%0d exp=6", edges);
    end
    do_wh_hs();
  endtask

  task automatic test_saturate();
    int ok, edges, wrong;
    logic [OW-1:0] exp;
    logic [WHW-1:0] lit;
`ifdef WH_SATURATE_EN
    lit = 12'd2047;
`else
    lit = 12'd1546;
`endif
    fill_w(1);
    new_row_rand(10);
    for (int e = 0; e < 10; e++) ev[e] = 127;
    exp = model_row(7, 1);
    run_to_out(7, 1, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL sat_pos_data got=%h exp=%h", wh_data_o, exp);
    end
    wrong = 0;
    for (int k = 0; k < NFO; k++) if (wh_data_o[NNW+1+k*WHW +: WHW] !== lit) wrong++;
    total++;
    if (wrong !== 0) begin
      bad++;
      $display("[TB] FAIL sat_pos_lanes got=%0d exp=%0d wrong=%0d", wh_data_o[NNW+1 +: WHW], lit, wrong);
    end
    do_wh_hs();
    for (int e = 0; e < 10; e++) ev[e] = -128;
    exp = model_row(8, 0);
    run_to_out(8, 0, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL sat_neg_data got=%h exp=%h", wh_data_o, exp);
    end
    do_wh_hs();
  endtask

  task automatic test_back_to_back();
    int ok, edges, nn, fl;
    logic [OW-1:0] exp;
    fill_w(2);
    for (int r = 0; r < 8; r++) begin
      new_row_rand(int'($urandom_range(0, 12)));
      nn = int'($urandom_range(0, MAXN - 1));
      fl = int'($urandom_range(0, 1));
      exp = model_row(nn, fl);
      run_to_out(nn, fl, 1'($urandom_range(0, 1)), ok, edges);
      total++;
      if (ok !== 1) begin
        bad++;
        $display("[TB] FAIL b2b_handshake row=%0d got=%0d exp=1", r, ok);
      end
      repeat (int'($urandom_range(0, 3))) step();
      total++;
      if (wh_data_o !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_data row=%0d got=%h exp=%h", r, wh_data_o, exp);
      end
      do_wh_hs();
    end
  endtask

  task automatic test_reset_mid_mac();
    int ok, edges;
    logic [OW-1:0] exp;
    new_row_rand(5);
    send_hdr(3, 1, ok);
    h_vld_i = 1'b1;
    h_data_i = {DW'(ev[0]), CW'(ec[0])};
    step();
    h_data_i = {DW'(ev[1]), CW'(ec[1])};
    step();
    h_data_i = {DW'(ev[2]), CW'(ec[2])};
    #2;
    rst_n = 1'b0;
    h_vld_i = 1'b0;
    #1;
    total++;
    if ({ni_rdy_o, h_rdy_o, wh_vld_o, busy_o} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_ctrl got=%b exp=0000", {ni_rdy_o, h_rdy_o, wh_vld_o, busy_o});
    end
    total++;
    if (wh_data_o !== '0 || addrb !== '0) begin
      bad++;
      $display("[TB] FAIL rstmid_data got=%h addr=%h exp=0", wh_data_o, addrb);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    new_row_rand(5);
    exp = model_row(44, 1);
    run_to_out(44, 1, 1'b0, ok, edges);
    total++;
    if (ok !== 1 || wh_data_o !== exp) begin
      bad++;
      $display("[TB] FAIL rstmid_next got=%h exp=%h", wh_data_o, exp);
    end
    do_wh_hs();
  endtask

  initial begin
    fill_w(0);
    test_reset();
    test_idle_hold();
    test_basic();
    test_empty_row();
    test_backpressure();
    test_gaps();
    test_saturate();
    test_back_to_back();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
